adder_sub: RTL and testbench



---
 rtl/adder_sub_pkg.sv | 9 +
 rtl/full_adder.sv | 13 +
 rtl/adder_sub.sv | 68 ++++++
 tb/tb_adder_sub.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/adder_sub_pkg.sv
// Shared constants for the adder_sub arithmetic unit: mode encodings and default width.
package adder_sub_pkg;

  localparam logic SUM   = 1'b0;
  localparam logic MINUS = 1'b1;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; chained by adder_sub to form the ripple-carry datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder_sub.sv
// Registered ripple-carry add/subtract unit with one-cycle latency.
// Define ADDER_SUB_OVERFLOW_EN to add the signed-overflow output (ovf) and its register.
module adder_sub
  import adder_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             out_valid
`ifdef ADDER_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  logic             inv;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   c;

  // Subtraction is a + ~b + 1: invert b and feed the +1 through the chain carry-in.
  assign inv   = (mode == MINUS);
  assign b_eff = b ^ {WIDTH{inv}};
  assign c[0]  = inv;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder u_fa (
      .a   (a[i]),
      .b   (b_eff[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out  <= sum;
        cout <= c[WIDTH];
      end
    end
  end

`ifdef ADDER_SUB_OVERFLOW_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= c[WIDTH] ^ c[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_adder_sub.sv
// Self-checking bench for adder_sub: arithmetic reference model plus directed literal checks.
module tb_adder_sub;

  localparam int W = 4;
  localparam int MOD = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         mode;
  logic         in_valid;
  logic [W-1:0] out;
  logic         cout;
  logic         out_valid;
`ifdef ADDER_SUB_OVERFLOW_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: what the output registers must hold
  int m_out = 0;
  int m_cout = 0;
  int m_ovf = 0;
  int m_valid = 0;

  adder_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .mode     (mode),
    .in_valid (in_valid),
    .out      (out),
    .cout     (cout),
    .out_valid(out_valid)
`ifdef ADDER_SUB_OVERFLOW_EN
    ,
    .ovf      (ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain integer arithmetic: modular result, unsigned carry/no-borrow, signed range test.
  task automatic model_op(input int ua, input int ub, input int m);
    int sa, sb, sr;
    sa = (ua >= HALF) ? ua - MOD : ua;
    sb = (ub >= HALF) ? ub - MOD : ub;
    if (m == 0) begin
      m_out  = (ua + ub) % MOD;
      m_cout = (ua + ub >= MOD) ? 1 : 0;
      sr     = sa + sb;
    end else begin
      m_out  = (ua - ub + MOD) % MOD;
      m_cout = (ua >= ub) ? 1 : 0;
      sr     = sa - sb;
    end
    m_ovf = (sr < -HALF || sr > HALF - 1) ? 1 : 0;
  endtask

  // One clock cycle: drive, let the edge sample, update model, compare after the edge.
  task automatic step(input logic v, input logic r, input int x, input int y, input logic m);
    in_valid = v;
    rst      = r;
    a        = x[W-1:0];
    b        = y[W-1:0];
    mode     = m;
    @(posedge clk);
    if (r) begin
      m_out = 0; m_cout = 0; m_ovf = 0; m_valid = 0;
    end else begin
      m_valid = v ? 1 : 0;
      if (v) model_op(x % MOD, y % MOD, m ? 1 : 0);
    end
    #1;
    check("mdl_out", int'(out), m_out);
    check("mdl_cout", int'(cout), m_cout);
    check("mdl_out_valid", int'(out_valid), m_valid);
`ifdef ADDER_SUB_OVERFLOW_EN
    check("mdl_ovf", int'(ovf), m_ovf);
`endif
  endtask

  initial begin
    in_valid = 1'b0; rst = 1'b1; a = '0; b = '0; mode = 1'b0;

    // Reset held two cycles with a valid operation presented: must be discarded
    step(1'b1, 1'b1, 5, 3, 1'b0);
    check("rst_out_0", int'(out), 0);
    check("rst_valid_0", int'(out_valid), 0);
    step(1'b1, 1'b1, 7, 7, 1'b0);
    check("rst_out_1", int'(out), 0);
    check("rst_cout_1", int'(cout), 0);
    check("rst_valid_1", int'(out_valid), 0);
    step(1'b1, 1'b0, 1, 2, 1'b0);
    check("post_rst_out", int'(out), 3);
    check("post_rst_valid", int'(out_valid), 1);

    // 3 - (-8): 0011 - 1000 = 1011, borrow, signed overflow
    step(1'b1, 1'b0, 3, 8, 1'b1);
    check("minus_out", int'(out), 11);
    check("minus_cout", int'(cout), 0);
`ifdef ADDER_SUB_OVERFLOW_EN
    check("minus_ovf", int'(ovf), 1);
`endif

    // -8 + -8 = 0000 with carry, signed overflow
    step(1'b1, 1'b0, 8, 8, 1'b0);
    check("sum_out", int'(out), 0);
    check("sum_cout", int'(cout), 1);
`ifdef ADDER_SUB_OVERFLOW_EN
    check("sum_ovf", int'(ovf), 1);
`endif

    // Back-to-back with mode flip
    step(1'b1, 1'b0, 5, 2, 1'b0);
    check("b2b_sum_out", int'(out), 7);
    check("b2b_sum_cout", int'(cout), 0);
    check("b2b_sum_valid", int'(out_valid), 1);
    step(1'b1, 1'b0, 5, 2, 1'b1);
    check("b2b_minus_out", int'(out), 3);
    check("b2b_minus_cout", int'(cout), 1);
    check("b2b_minus_valid", int'(out_valid), 1);

    // Hold: idle cycles with changing operands
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, i * 5 + 1, 15 - i, i[0]);
      check("hold_out", int'(out), 3);
      check("hold_cout", int'(cout), 1);
      check("hold_valid", int'(out_valid), 0);
    end

    // Reset mid-stream clears the result register
    step(1'b1, 1'b0, 9, 4, 1'b0);
    step(1'b1, 1'b1, 7, 7, 1'b0);
    check("mid_rst_out", int'(out), 0);
    check("mid_rst_valid", int'(out_valid), 0);
    step(1'b1, 1'b0, 1, 1, 1'b0);
    check("mid_rst_first", int'(out), 2);

    // Exhaustive a/b/mode sweep
    for (int i = 0; i < 512; i++) begin
      step(1'b1, 1'b0, int'(i[3:0]), int'(i[7:4]), i[8]);
    end

    // Randomized traffic with idle gaps and occasional resets
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
           int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)),
           $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
